// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet decoder: flit type codes, the
// spike packet class, per-VC context states and field-offset helpers.
package noc_pkg;

  localparam logic [1:0] HDR  = 2'b10;
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b01;

  localparam logic [2:0]  PCLASS_SPIKE = 3'd0;
  localparam int unsigned PCLASS_W     = 3;

  typedef enum logic {
    CTX_IDLE = 1'b0,
    CTX_OPEN = 1'b1
  } ctx_state_e;

  // Field offsets, LSB first: data | sub[2] | para[2] | nid | kind | vc | type[2]
  function automatic int unsigned sub_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned para_lsb(input int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned nid_lsb(input int unsigned data_w);
    return data_w + 4;
  endfunction

  function automatic int unsigned kind_lsb(input int unsigned nid_w, input int unsigned data_w);
    return nid_w + data_w + 4;
  endfunction

  function automatic int unsigned vc_lsb(input int unsigned kind_w, input int unsigned nid_w,
                                         input int unsigned data_w);
    return kind_w + nid_w + data_w + 4;
  endfunction

  function automatic int unsigned type_lsb(input int unsigned vc_w, input int unsigned kind_w,
                                           input int unsigned nid_w, input int unsigned data_w);
    return vc_w + kind_w + nid_w + data_w + 4;
  endfunction

  function automatic int unsigned flit_width(input int unsigned vc_w, input int unsigned kind_w,
                                             input int unsigned nid_w, input int unsigned data_w);
    return type_lsb(vc_w, kind_w, nid_w, data_w) + 2;
  endfunction

endpackage

// File: rtl/noc_packet_decoder_mc_vc_context.sv
// One virtual-channel reassembly context: open flag plus the packet class
// latched from the header, with the open/close and protocol-error decisions.
module vc_context
  import noc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sel,
  input  logic [1:0] i_type,
  input  logic [2:0] i_pclass,
  output logic       o_open,
  output logic [2:0] o_pclass,
  output logic       o_event,
  output logic       o_err
);

  ctx_state_e r_state;
  logic [2:0] r_pclass;
  logic       w_is_hdr;
  logic       w_is_data;

  // Classify the flit routed to this context and decide event / error
  always_comb begin
    w_is_hdr  = (i_type == HDR);
    w_is_data = (i_type == BODY) || (i_type == TAIL);
    o_event   = i_sel && w_is_data && (r_state == CTX_OPEN);
    o_err     = i_sel && ((w_is_hdr && (r_state == CTX_OPEN)) ||
                          (w_is_data && (r_state == CTX_IDLE)));
  end

  // Context state: a header (re)opens and latches pclass, a tail closes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= CTX_IDLE;
      r_pclass <= '0;
    end else if (i_sel && w_is_hdr) begin
      r_state  <= CTX_OPEN;
      r_pclass <= i_pclass;
    end else if (o_event && (i_type == TAIL)) begin
      r_state  <= CTX_IDLE;
    end
  end

  assign o_open   = (r_state == CTX_OPEN);
  assign o_pclass = r_pclass;

endmodule

// File: rtl/noc_packet_decoder_mc.sv
// Multi-VC neuron-side packet decoder: reassembles header/body/tail flits per
// virtual channel and emits one spike or write event per body/tail flit.
module noc_packet_decoder_mc
  import noc_pkg::*;
#(
  parameter int unsigned NUM_VC = 4,
  parameter int unsigned VC_W   = 4,
  parameter int unsigned KIND_W = 4,
  parameter int unsigned NID_W  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FLIT_W = 2 + VC_W + KIND_W + NID_W + 4 + DATA_W
) (
  input  logic              neuron_clk,
  input  logic              neuron_rst_n,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_is_spike,
  output logic [2:0]        ev_pclass,
  output logic [KIND_W-1:0] ev_kind,
  output logic [NID_W-1:0]  ev_nid,
  output logic [1:0]        ev_para,
  output logic [1:0]        ev_sub,
  output logic [DATA_W-1:0] ev_data,
  output logic              ev_last,
  output logic [NUM_VC-1:0] vc_open,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);

  localparam int unsigned SUB_LSB  = sub_lsb(DATA_W);
  localparam int unsigned PARA_LSB = para_lsb(DATA_W);
  localparam int unsigned NID_LSB  = nid_lsb(DATA_W);
  localparam int unsigned KIND_LSB = kind_lsb(NID_W, DATA_W);
  localparam int unsigned VC_LSB   = vc_lsb(KIND_W, NID_W, DATA_W);
  localparam int unsigned TYPE_LSB = type_lsb(VC_W, KIND_W, NID_W, DATA_W);

  if (FLIT_W != flit_width(VC_W, KIND_W, NID_W, DATA_W)) begin : g_bad_flit_w
    $error("noc_packet_decoder_mc: FLIT_W does not match the field widths");
  end

  logic [1:0]        w_type;
  logic [VC_W-1:0]   w_vc;
  logic [2:0]        w_hdr_pclass;
  logic              w_accept;
  logic              w_vc_ok;
  logic              w_illegal;
  logic              w_ev;
  logic              w_err;
  logic [NUM_VC-1:0] w_sel;
  logic [NUM_VC-1:0] w_ctx_ev;
  logic [NUM_VC-1:0] w_ctx_err;
  logic [2:0]        w_ctx_pclass [NUM_VC];
  logic [2:0]        w_ev_pclass;

  logic              r_ev_valid;
  logic              r_ev_is_spike;
  logic [2:0]        r_ev_pclass;
  logic [KIND_W-1:0] r_ev_kind;
  logic [NID_W-1:0]  r_ev_nid;
  logic [1:0]        r_ev_para;
  logic [1:0]        r_ev_sub;
  logic [DATA_W-1:0] r_ev_data;
  logic              r_ev_last;
  logic              r_err_pulse;
  logic [7:0]        r_err_cnt;

  // Accept whenever the event slot is empty or being drained this cycle
  assign flit_ready = !r_ev_valid || ev_ready;

  // Decode the flit, steer it to its context and gather event / error status
  always_comb begin
    w_type       = flit_data[TYPE_LSB +: 2];
    w_vc         = flit_data[VC_LSB +: VC_W];
    w_hdr_pclass = flit_data[VC_LSB-1 -: PCLASS_W];
    w_accept     = flit_valid && flit_ready;
    w_vc_ok      = (32'(w_vc) < NUM_VC);
    w_illegal    = (w_type == 2'b11);
    w_sel        = '0;
    w_ev_pclass  = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (w_vc == VC_W'(i)) begin
        w_sel[i]    = w_accept && w_vc_ok && !w_illegal;
        w_ev_pclass = w_ctx_pclass[i];
      end
    end
    w_ev  = |w_ctx_ev;
    w_err = w_accept && (w_illegal || !w_vc_ok || (|w_ctx_err));
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_ctx
    vc_context u_ctx (
      .i_clk    (neuron_clk),
      .i_rst_n  (neuron_rst_n),
      .i_sel    (w_sel[g]),
      .i_type   (w_type),
      .i_pclass (w_hdr_pclass),
      .o_open   (vc_open[g]),
      .o_pclass (w_ctx_pclass[g]),
      .o_event  (w_ctx_ev[g]),
      .o_err    (w_ctx_err[g])
    );
  end

  // Event register: reload on a new body/tail, otherwise drain on ev_ready
  always_ff @(posedge neuron_clk or negedge neuron_rst_n) begin
    if (!neuron_rst_n) begin
      r_ev_valid    <= 1'b0;
      r_ev_is_spike <= 1'b0;
      r_ev_pclass   <= '0;
      r_ev_kind     <= '0;
      r_ev_nid      <= '0;
      r_ev_para     <= '0;
      r_ev_sub      <= '0;
      r_ev_data     <= '0;
      r_ev_last     <= 1'b0;
    end else if (w_ev) begin
      r_ev_valid    <= 1'b1;
      r_ev_is_spike <= (w_ev_pclass == PCLASS_SPIKE);
      r_ev_pclass   <= w_ev_pclass;
      r_ev_kind     <= flit_data[KIND_LSB +: KIND_W];
      r_ev_nid      <= flit_data[NID_LSB +: NID_W];
      r_ev_para     <= flit_data[PARA_LSB +: 2];
      r_ev_sub      <= flit_data[SUB_LSB +: 2];
      r_ev_data     <= flit_data[DATA_W-1:0];
      r_ev_last     <= (w_type == TAIL);
    end else if (ev_ready) begin
      r_ev_valid    <= 1'b0;
    end
  end

  // Error pulse and saturating drop counter
  always_ff @(posedge neuron_clk or negedge neuron_rst_n) begin
    if (!neuron_rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign ev_valid    = r_ev_valid;
  assign ev_is_spike = r_ev_is_spike;
  assign ev_pclass   = r_ev_pclass;
  assign ev_kind     = r_ev_kind;
  assign ev_nid      = r_ev_nid;
  assign ev_para     = r_ev_para;
  assign ev_sub      = r_ev_sub;
  assign ev_data     = r_ev_data;
  assign ev_last     = r_ev_last;
  assign err_pulse   = r_err_pulse;
  assign err_cnt     = r_err_cnt;

endmodule

// File: doc/noc_packet_decoder_mc.md
# noc_packet_decoder_mc

Parametrised, multi-VC successor to the neuron-side packet decoder. Accepts flits from the network interface over a valid/ready handshake, keeps an independent reassembly context per virtual channel, and turns each body/tail flit into one decoded event: a spike or a parameter/memory write. Protocol violations are dropped and counted. Sits between `network_interface` and the neuron core in the neuron clock domain.

## Interface
- `NUM_VC`, 4: number of reassembly contexts; VC field values 0..NUM_VC-1 are legal.
- `VC_W`, 4: width of the flit VC field.
- `KIND_W`, 4: width of the body kind field.
- `NID_W`, 8: width of the neuron-id field.
- `DATA_W`, 16: width of the payload field.
- `FLIT_W`, 2+VC_W+KIND_W+NID_W+4+DATA_W (38 at defaults): flit width. Any other value is an elaboration error.
- `neuron_clk` in 1: the only clock.
- `neuron_rst_n` in 1: asynchronous, active-low reset.
- `flit_valid` in 1: `flit_data` is valid.
- `flit_ready` out 1: the decoder accepts the flit this cycle.
- `flit_data` in FLIT_W: the flit.
- `ev_valid` out 1: a decoded event is held.
- `ev_ready` in 1: the consumer takes the event.
- `ev_is_spike` out 1: 1 = spike event, 0 = write event.
- `ev_pclass` out 3: packet class latched from the header.
- `ev_kind` out KIND_W, `ev_nid` out NID_W, `ev_para` out 2, `ev_sub` out 2, `ev_data` out DATA_W: decoded body fields.
- `ev_last` out 1: the event came from a tail flit.
- `vc_open` out NUM_VC: per-VC "packet in progress" flags.
- `err_pulse` out 1: one-cycle pulse on a dropped flit.
- `err_cnt` out 8: saturating count of dropped flits.

## Operation
- Flit layout, MSB first: type[2] | vc[VC_W] | rest.
  - type encoding: 10 = header, 00 = body, 01 = tail, 11 = illegal.
  - Header rest: pclass[3] in the top bits; the remaining routing bits are ignored.
  - Body/tail rest: kind | nid | para[2] | sub[2] | data.
- Per-VC context: `open` bit plus `pclass[3]`. Context state machine per VC is IDLE → (header) OPEN → (tail) IDLE. A body flit keeps the context in OPEN.
- A flit is accepted when `flit_valid && flit_ready`. `flit_ready = !ev_valid || ev_ready`. Header flits obey the same rule.
- Accepted header:
  - Context in IDLE: open it and latch pclass. No event.
  - Context already OPEN: error. Reopen with the new pclass.
- Accepted body or tail on an OPEN context: load the event register.
  - `ev_is_spike = (pclass == 0)`.
  - `ev_pclass` takes the context pclass; field outputs come straight from the flit.
  - `ev_last = 1` for a tail. A tail also closes the context.
- Dropped with error (no event, context unchanged):
  - body or tail on an IDLE context;
  - type 11;
  - vc ≥ NUM_VC.
- Every error raises `err_pulse` for one cycle and increments `err_cnt`, which saturates at 255.
- The event register holds its contents while `ev_valid && !ev_ready`.

## Timing
- Reset values: `ev_valid` 0, all `ev_*` fields 0, `vc_open` 0, `err_pulse` 0, `err_cnt` 0, `flit_ready` 1.
- Latency: a body or tail accepted on cycle N gives `ev_valid = 1` on cycle N+1.
- Throughput: one flit per cycle when `ev_ready` is held at 1. No bubbles, including header then body back-to-back on the same VC.
- Event handshake: when `ev_valid && ev_ready` and a new event-producing flit is accepted in the same cycle, the register reloads and `ev_valid` stays 1.
- Context update: `vc_open` changes one cycle after acceptance. A header and its tail may arrive on consecutive cycles.
- Interleaving: flits from different VCs may interleave freely, and each context is independent.
- Reset asserted mid-packet: all contexts close immediately and any pending event is lost. After reset, a body flit for that packet counts as an error.

## Structure
- Package `noc_pkg` holds:
  - flit type localparams (HDR = 2'b10, BODY = 2'b00, TAIL = 2'b01);
  - the `PCLASS_SPIKE = 3'd0` constant;
  - field-offset functions derived from the parameters.
- One sub-module, `vc_context`, instantiated NUM_VC times. It holds the open/pclass state and its set/clear/error logic.

## Test plan
- Header (vc 1, pclass 2) then tail (kind 0010, nid 0x02, data 0x01E0) back-to-back → one event on the cycle after the tail: `ev_is_spike` 0, `ev_pclass` 2, nid 0x02, data 0x01E0, `ev_last` 1. `vc_open[1]` returns to 0.
- Spike packet: header pclass 0 on vc 1, then tail nid 0x03 → `ev_is_spike` 1, nid 0x03.
- Header, body×2, tail (kind 0101, para 0/1/2) with `ev_ready` held 0 for 3 cycles after the first event → `flit_ready` is 0 during the stall, no event is lost, and the events come out in para order 0, 1, 2.
- Interleaved headers on vc 0 and vc 2, then tails in reverse order → each event carries its own VC's pclass.
- Error cases, each giving one `err_pulse` and `err_cnt` +1, with no event and contexts unchanged:
  - body on an idle vc;
  - type 11;
  - vc = 7 at NUM_VC = 4.
- Force 300 errors → `err_cnt` saturates at 255. Assert `neuron_rst_n` mid-packet → `vc_open` is 0 and the following tail counts as an error.
